// File: rtl/shift_deser_pkg.sv
// Shared types and helpers for the MSB-first serial deserializer.
// Optional parity framing is enabled by defining SHIFT_DESER_PARITY_EN.
package shift_deser_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Number of strobed bits per frame: data bits plus the optional parity bit.
  function automatic int frame_len(input int width, input bit par_en);
    return par_en ? width + 1 : width;
  endfunction

  function automatic logic parity_of(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/shift_deser_shreg.sv
// Bit counter and MSB-first shift register; flags the strobe that completes a frame.
// With SHIFT_DESER_PARITY_EN the trailing parity bit is checked, not shifted in.
module shift_deser_shreg #(
  parameter int WIDTH = 8,
  parameter int FRAME = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_i,
  input  logic             sdata_i,
  input  logic             clear_i,
  output logic             done_o,
  output logic [WIDTH-1:0] word_o,
`ifdef SHIFT_DESER_PARITY_EN
  output logic             perr_o,
`endif
  output logic             busy_o
);
  import shift_deser_pkg::*;

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             busy_q;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    done_o = 1'b0;
    word_o = PARITY_EN ? sh_q : {sh_q[WIDTH-2:0], sdata_i};
    if (clear_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (shift_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // The parity bit (last strobe of a parity frame) never enters the word.
      if (!PARITY_EN || (cnt_q != LAST)) sh_d = {sh_q[WIDTH-2:0], sdata_i};
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  assign perr_o = parity_of(32'(sh_q)) ^ sdata_i;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-word output register and valid/ready handshake.
// Optional even-parity framing via SHIFT_DESER_PARITY_EN.
//
// state     | meaning
// OUT_EMPTY | no unaccepted word, out_valid=0
// OUT_FULL  | data_out holds a word awaiting out_ready
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             sdata,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
  import shift_deser_pkg::*;

  localparam int FRAME = frame_len(WIDTH, PARITY_EN);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             done;
  logic             hs;
  logic [WIDTH-1:0] word;
`ifdef SHIFT_DESER_PARITY_EN
  logic             frame_perr;
  logic             perr_q, perr_d;
`endif

  shift_deser_shreg #(
    .WIDTH (WIDTH),
    .FRAME (FRAME)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .shift_i (shift),
    .sdata_i (sdata),
    .clear_i (clear),
    .done_o  (done),
    .word_o  (word),
`ifdef SHIFT_DESER_PARITY_EN
    .perr_o  (frame_perr),
`endif
    .busy_o  (busy)
  );

  assign hs = (state_q == OUT_FULL) && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
`ifdef SHIFT_DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    if (done) begin
      // A completed word is taken only if the slot is free or being emptied now.
      if ((state_q == OUT_EMPTY) || hs) begin
        state_d = OUT_FULL;
        data_d  = word;
`ifdef SHIFT_DESER_PARITY_EN
        perr_d  = frame_perr;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      state_d = OUT_EMPTY;
    end
    if (clear) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = data_q;
  assign out_valid = (state_q == OUT_FULL);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH=8); accepted words are scored
// against a queue of expected words. Parity cases run when SHIFT_DESER_PARITY_EN is defined.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       reset, shift, sdata, clear, out_ready;
  logic [7:0] data_out;
  logic       out_valid, busy, overrun, parity_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  shift_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .shift      (shift),
    .sdata      (sdata),
    .clear      (clear),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake occurs on the coming edge: score the word being accepted.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_accept", 32'(data_out), 32'hFFFF_FFFF);
      else                chk("sb_data", 32'(data_out), 32'(sb.pop_front()));
    end
  end

  task automatic send_bits(input logic [8:0] bits, input int n, input bit toggle,
                           input bit push, input logic [7:0] w, input bit rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      shift = 1'b1;
      sdata = bits[i];
      if (i == 0 && push)     sb.push_back(w);
      if (i == 0 && rdy_last) out_ready = 1'b1;
      tick();
      if (toggle && i != 0) begin
        chk("busy_mid", 32'(busy), 32'd1);
        shift = 1'b0;
        tick();
      end
    end
    shift = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit toggle, input bit push,
                           input bit rdy_last);
`ifdef SHIFT_DESER_PARITY_EN
    send_bits({w, ^w}, 9, toggle, push, w, rdy_last);
`else
    send_bits({1'b0, w}, 8, toggle, push, w, rdy_last);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; shift = 1'b0; sdata = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    reset = 1'b1;
    repeat (5) tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_data", 32'(data_out), 32'h0);

    // Plain word, consumer ready
    out_ready = 1'b1;
    send_word(8'h65, 1'b0, 1'b1, 1'b0);
    chk("w65_valid", 32'(out_valid), 32'd1);
    chk("w65_data", 32'(data_out), 32'h65);
    chk("w65_busy", 32'(busy), 32'd0);
    tick();
    chk("w65_hs_valid", 32'(out_valid), 32'd0);
    chk("w65_hold_data", 32'(data_out), 32'h65);

    // Gapped strobes
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("wA5_data", 32'(data_out), 32'hA5);
    chk("wA5_valid", 32'(out_valid), 32'd1);
    tick();
    chk("wA5_hs_valid", 32'(out_valid), 32'd0);

    // Overrun then clear
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("w3C_valid", 32'(out_valid), 32'd1);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("ovr_data", 32'(data_out), 32'h3C);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd1);
    chk("clr_data", 32'(data_out), 32'h3C);
    out_ready = 1'b1;
    tick();
    chk("w3C_hs_valid", 32'(out_valid), 32'd0);

    // Completion coincident with handshake
    out_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b1, 1'b0);
    send_word(8'h22, 1'b0, 1'b1, 1'b1);
    chk("coin_data", 32'(data_out), 32'h22);
    chk("coin_valid", 32'(out_valid), 32'd1);
    chk("coin_ovr", 32'(overrun), 32'd0);
    tick();
    chk("coin_hs_valid", 32'(out_valid), 32'd0);

    // Back-to-back words, ready tied high
    send_word(8'h81, 1'b0, 1'b1, 1'b0);
    chk("b2b1_data", 32'(data_out), 32'h81);
    send_word(8'h7E, 1'b0, 1'b1, 1'b0);
    chk("b2b2_data", 32'(data_out), 32'h7E);
    chk("b2b_ovr", 32'(overrun), 32'd0);
    tick();

    // Clear mid-word with a simultaneous strobe discards the partial word
    send_bits(9'h1FF, 3, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("part_busy", 32'(busy), 32'd1);
    clear = 1'b1; shift = 1'b1; sdata = 1'b1;
    tick();
    clear = 1'b0; shift = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    send_word(8'h96, 1'b0, 1'b1, 1'b0);
    chk("w96_data", 32'(data_out), 32'h96);
    tick();

    // Reset mid-word
    send_bits(9'h00A, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    send_word(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("w5A_data", 32'(data_out), 32'h5A);
    chk("w5A_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef SHIFT_DESER_PARITY_EN
    send_bits({8'h65, 1'b0}, 9, 1'b0, 1'b1, 8'h65, 1'b0);
    chk("par_good_data", 32'(data_out), 32'h65);
    chk("par_good_err", 32'(parity_err), 32'd0);
    tick();
    send_bits({8'h65, 1'b1}, 9, 1'b0, 1'b1, 8'h65, 1'b0);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    tick();
    // Dropped frame must not touch parity_err
    out_ready = 1'b0;
    send_bits({8'h01, 1'b1}, 9, 1'b0, 1'b1, 8'h01, 1'b0);
    chk("par_load_ok", 32'(parity_err), 32'd0);
    send_bits({8'h01, 1'b0}, 9, 1'b0, 1'b0, 8'h01, 1'b0);
    chk("par_drop_err", 32'(parity_err), 32'd0);
    chk("par_drop_ovr", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    tick();
`else
    chk("perr_const", 32'(parity_err), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
